// File: rtl/mmio_responder_if.sv
// CPU-side MMIO bus: I/O strobes, window offset, store data and load data.
interface mmio_responder_if;
  logic        io_read;
  logic        io_write;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output io_read, io_write, addr, wdata, input rdata);
  modport slave  (input io_read, io_write, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder: synchronised switches, debounced buttons with sticky
// press flags, LED / seven-segment registers and a free-running cycle counter.
// Loads are combinational so a lw completes in its single cycle.

// One button lane: 2-flop synchroniser, debounce counter, sticky press flag.
module mmio_btn_lane #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic clr,     // BTN read this cycle: drop the press flag
  output logic db,
  output logic press
);
  logic             s1_q, s1_d, s2_q, s2_d, db_q, db_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: count while the synced input disagrees, accept at the limit.
  always_comb begin
    s1_d    = btn_in;
    s2_d    = s1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d  = s2_q;
      else                                      cnt_d = cnt_q + 1'b1;
    end
    // A rise on the same edge as a clearing read keeps the flag set.
    press_d = (press_q & ~clr) | (db_d & ~db_q);
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0; s2_q <= 1'b0; db_q <= 1'b0; press_q <= 1'b0; cnt_q <= '0;
    end else begin
      s1_q <= s1_d; s2_q <= s2_d; db_q <= db_d; press_q <= press_d; cnt_q <= cnt_d;
    end
  end

  assign db    = db_q;
  assign press = press_q;
endmodule

module mmio_responder #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mmio_responder_if.slave          bus,
  input  logic [15:0]              sw_in,
  input  logic [4:0]               btn_in,
  output logic [15:0]              led_out,
  output logic [31:0]              seg_data,
  output logic                     addr_err
);
  localparam int NUM_LANES = 5;

  localparam logic [9:0] A_SW  = 10'h060;
  localparam logic [9:0] A_BTN = 10'h064;
  localparam logic [9:0] A_LED = 10'h070;
  localparam logic [9:0] A_SEG = 10'h074;
  localparam logic [9:0] A_CYC = 10'h078;

  logic [15:0] sw_s1_q, sw_s1_d, sw_sync_q, sw_sync_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d, cyc_q, cyc_d;
  logic        err_q, err_d;

  logic [NUM_LANES-1:0] btn_db, press;

  // Address decode: only the five word-aligned offsets are mapped.
  logic hit_sw, hit_btn, hit_led, hit_seg, hit_cyc, hit, access, both, rd_ok;
  always_comb begin
    hit_sw  = (bus.addr == A_SW);
    hit_btn = (bus.addr == A_BTN);
    hit_led = (bus.addr == A_LED);
    hit_seg = (bus.addr == A_SEG);
    hit_cyc = (bus.addr == A_CYC);
    hit     = hit_sw | hit_btn | hit_led | hit_seg | hit_cyc;
    access  = bus.io_read | bus.io_write;
    both    = bus.io_read & bus.io_write;
    // Simultaneous read+write behaves as a write, so it never drives rdata.
    rd_ok   = bus.io_read & ~bus.io_write & hit;
  end

  // Combinational load data.
  always_comb begin
    bus.rdata = '0;
    if (rd_ok) begin
      unique case (1'b1)
        hit_sw:  bus.rdata = {16'b0, sw_sync_q};
        hit_btn: bus.rdata = {11'b0, btn_db, 11'b0, press};
        hit_led: bus.rdata = {16'b0, led_q};
        hit_seg: bus.rdata = seg_q;
        hit_cyc: bus.rdata = cyc_q;
        default: bus.rdata = '0;
      endcase
    end
  end

  // Next-state for the bus-visible registers and the switch synchroniser.
  always_comb begin
    sw_s1_d   = sw_in;
    sw_sync_d = sw_s1_q;
    led_d     = led_q;
    seg_d     = seg_q;
    cyc_d     = cyc_q + 32'd1;
    err_d     = err_q | (access & (~hit | both));
    if (bus.io_write && hit_led) led_d = bus.wdata[15:0];
    if (bus.io_write && hit_seg) seg_d = bus.wdata;
    if (bus.io_write && hit_cyc) cyc_d = bus.wdata;
  end

  // Register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0; sw_sync_q <= '0; led_q <= '0; seg_q <= '0; cyc_q <= '0; err_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d; sw_sync_q <= sw_sync_d; led_q <= led_d;
      seg_q   <= seg_d;   cyc_q     <= cyc_d;     err_q <= err_d;
    end
  end

  // Button lanes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_btn
    mmio_btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in[i]),
      .clr    (rd_ok & hit_btn),
      .db     (btn_db[i]),
      .press  (press[i])
    );
  end

  assign led_out  = led_q;
  assign seg_data = seg_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: vector table for the bus registers plus
// hand-written sequences for synchroniser, debounce, press and reset cases.
module tb_mmio_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw_in = '0;
  logic [4:0]  btn_in = '0;
  logic [15:0] led_out;
  logic [31:0] seg_data;
  logic        addr_err;

  mmio_responder_if bus();

  mmio_responder #(.DEBOUNCE_CYCLES(20), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sw_in    (sw_in),
    .btn_in   (btn_in),
    .led_out  (led_out),
    .seg_data (seg_data),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rd, wr;
    logic [9:0]  addr;
    logic [31:0] wdata, exp_rd;
    logic [15:0] exp_led;
    logic [31:0] exp_seg;
    logic        exp_err;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t mk(logic rd, logic wr, logic [9:0] a, logic [31:0] wd,
                              logic [31:0] er, logic [15:0] el, logic [31:0] es, logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.exp_rd = er; v.exp_led = el; v.exp_seg = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] wd);
    bus.io_read = rd; bus.io_write = wr; bus.addr = a; bus.wdata = wd;
  endtask

  // Drive just after the edge, queue the expected load, compare at the negedge.
  task automatic bus_op(input string nm, input logic rd, input logic wr,
                        input logic [9:0] a, input logic [31:0] wd, input logic [31:0] er);
    @(posedge clk); #1;
    drive(rd, wr, a, wd);
    exp_q.push_back(er);
    @(negedge clk);
    chk(nm, bus.rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(0, 1, 10'h070, 32'hABCD1234, 32'h0,        16'h0000, 32'h0,        0);
    tbl[1]  = mk(1, 0, 10'h070, 32'h0,        32'h00001234, 16'h1234, 32'h0,        0);
    tbl[2]  = mk(0, 1, 10'h074, 32'hDEADBEEF, 32'h0,        16'h1234, 32'h0,        0);
    tbl[3]  = mk(1, 0, 10'h074, 32'h0,        32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 0);
    tbl[4]  = mk(1, 0, 10'h070, 32'h0,        32'h00001234, 16'h1234, 32'hDEADBEEF, 0);
    tbl[5]  = mk(0, 1, 10'h078, 32'hFFFFFFFE, 32'h0,        16'h1234, 32'hDEADBEEF, 0);
    tbl[6]  = mk(1, 0, 10'h078, 32'h0,        32'hFFFFFFFE, 16'h1234, 32'hDEADBEEF, 0);
    tbl[7]  = mk(1, 0, 10'h078, 32'h0,        32'hFFFFFFFF, 16'h1234, 32'hDEADBEEF, 0);
    tbl[8]  = mk(1, 0, 10'h078, 32'h0,        32'h00000000, 16'h1234, 32'hDEADBEEF, 0);
    tbl[9]  = mk(1, 0, 10'h064, 32'h0,        32'h00000000, 16'h1234, 32'hDEADBEEF, 0);
    tbl[10] = mk(1, 0, 10'h062, 32'h0,        32'h00000000, 16'h1234, 32'hDEADBEEF, 0);
    tbl[11] = mk(1, 0, 10'h070, 32'h0,        32'h00001234, 16'h1234, 32'hDEADBEEF, 1);
    tbl[12] = mk(0, 1, 10'h100, 32'h12345678, 32'h0,        16'h1234, 32'hDEADBEEF, 1);
    tbl[13] = mk(1, 0, 10'h070, 32'h0,        32'h00001234, 16'h1234, 32'hDEADBEEF, 1);
    tbl[14] = mk(1, 1, 10'h070, 32'h0000FFFF, 32'h0,        16'h1234, 32'hDEADBEEF, 1);
    tbl[15] = mk(1, 0, 10'h070, 32'h0,        32'h0000FFFF, 16'hFFFF, 32'hDEADBEEF, 1);
    tbl[16] = mk(1, 0, 10'h07C, 32'h0,        32'h00000000, 16'hFFFF, 32'hDEADBEEF, 1);

    // Reset state, counter held while in reset.
    drive(1, 0, 10'h078, 32'h0);
    @(negedge clk);
    chk("rst led", 32'(led_out), 32'h0);
    chk("rst seg", seg_data, 32'h0);
    chk("rst err", 32'(addr_err), 32'h0);
    chk("rst cyc", bus.rdata, 32'h0);
    @(negedge clk);
    chk("rst cyc held", bus.rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("cyc first", bus.rdata, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("cyc %0d", i), bus.rdata, 32'(i));
    end

    // Register vectors.
    for (int i = 0; i < 17; i++) begin
      bus_op($sformatf("vec%0d rdata", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d led", i), 32'(led_out), 32'(tbl[i].exp_led));
      chk($sformatf("vec%0d seg", i), seg_data, tbl[i].exp_seg);
      chk($sformatf("vec%0d err", i), 32'(addr_err), 32'(tbl[i].exp_err));
    end

    // Switch synchroniser: two edges of lag.
    @(posedge clk); #1;
    drive(1, 0, 10'h060, 32'h0);
    sw_in = 16'h5A5A;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h00005A5A);
    @(negedge clk); chk("sw lag0", bus.rdata, exp_q.pop_front());
    @(negedge clk); chk("sw lag1", bus.rdata, exp_q.pop_front());
    @(negedge clk); chk("sw lag2", bus.rdata, exp_q.pop_front());

    // Button 2 held: accepted on edge 22; clearing read on that edge loses to the rise.
    @(posedge clk); #1;
    drive(0, 0, 10'h0, 32'h0);
    btn_in[2] = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    drive(1, 0, 10'h064, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk); chk("btn edge21", bus.rdata, exp_q.pop_front());
    exp_q.push_back(32'h00040004);
    @(negedge clk); chk("btn edge22", bus.rdata, exp_q.pop_front());
    exp_q.push_back(32'h00040000);
    @(negedge clk); chk("btn cleared", bus.rdata, exp_q.pop_front());
    @(posedge clk); #1;
    drive(0, 0, 10'h0, 32'h0);
    @(posedge clk); #1;
    btn_in[2] = 1'b0;
    repeat (30) @(posedge clk);
    // Short pulse on button 0 never passes the debouncer.
    #1;
    btn_in[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btn_in[0] = 1'b0;
    repeat (30) @(posedge clk);
    bus_op("btn glitch", 1, 0, 10'h064, 32'h0, 32'h0);

    // Reset in the middle of a write.
    @(posedge clk); #1;
    drive(0, 1, 10'h070, 32'h000000AA);
    @(negedge clk);
    chk("pre-rst led", 32'(led_out), 32'h0000FFFF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst led", 32'(led_out), 32'h0);
    chk("midrst err", 32'(addr_err), 32'h0);
    chk("midrst seg", seg_data, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 10'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_op("post-rst led read", 1, 0, 10'h070, 32'h0, 32'h0);
    chk("post-rst err", 32'(addr_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder for the single-cycle MIPS core; the device end of the IORead/IOWrite strobes the controller raises for any lw/sw whose address[31:10] is all ones (window 0xFFFFFC00–0xFFFFFFFF).
- Owns the board peripherals:
  - 2-flop synchronised switch inputs
  - debounced push-buttons with sticky press flags
  - LED and seven-segment output registers
  - a free-running cycle counter.
- Reads are combinational so lw completes in its single cycle; all state changes occur on the clock edge.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive stable cycles before a button change is accepted (board build overrides to 1_000_000).
- CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES (board build overrides to 20).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- io_read  in  1  I/O read strobe from controller.
- io_write  in  1  I/O write strobe from controller.
- addr  in  10  ALU result bits [9:0], byte address within I/O window.
- wdata  in  32  store data (rt value).
- rdata  out  32  load data, combinational.
- sw_in  in  16  raw switches, asynchronous.
- btn_in  in  5  raw buttons, asynchronous, active-high.
- led_out  out  16  LED register.
- seg_data  out  32  seven-segment data register (8 nibbles, decoded by the display driver).
- addr_err  out  1  sticky flag: unmapped or misaligned access seen.

Behaviour:
- Reset (async, rst_n=0):
  - led_out=0, seg_data=0, addr_err=0, cycle counter=0.
  - Sync flops, debounced values, debounce counters and press flags all 0.
  - rdata is combinational from the reset state.
- Address map (addr, word-aligned):
  - 0x060 SW, R: {16'b0, sw_sync}.
  - 0x064 BTN, R: {11'b0, btn_db[4:0], 11'b0, press[4:0]}.
  - 0x070 LED, R/W: {16'b0, led_out}; write takes wdata[15:0].
  - 0x074 SEG, R/W: seg_data; write takes wdata[31:0].
  - 0x078 CYC, R/W: cycle counter; a write loads wdata.
- Read path:
  - rdata = mapped value when io_read=1 and addr hits; otherwise 0.
  - No latency.
- Write path:
  - Target register updates on the rising edge where io_write=1 and addr hits.
  - The new value is visible on rdata the following cycle.
- Unmapped address, or addr[1:0]!=0, with io_read or io_write set:
  - rdata=0, no write takes effect.
  - addr_err set at the edge and held until reset.
- If io_read and io_write are both 1 (illegal): treat as a write; rdata=0; addr_err set.
- Switches:
  - sw_in passes through a 2-flop synchroniser.
  - sw_sync lags sw_in by 2 edges.
- Buttons, per bit:
  - 2-flop synchroniser, then debounce.
  - When the synced value differs from btn_db, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_db takes the synced value and the counter clears.
  - Any cycle where synced==btn_db clears the counter, so a glitch restarts the count.
  - Accept latency = 2 + DEBOUNCE_CYCLES edges after a stable input change.
- Press flags:
  - press[i] is set on the edge where btn_db[i] rises 0→1.
  - A read of BTN (io_read=1, addr=0x064) clears all press bits at that edge.
  - rdata during the clearing read shows the pre-clear value.
  - A rise coinciding with the clearing read leaves press[i]=1 (set wins).
- Cycle counter:
  - Increments by 1 every edge and wraps 0xFFFFFFFF→0.
  - A write of CYC loads wdata and suppresses the increment that edge.
  - Read value is the current register value.
- Mid-operation reset: all state returns to reset values immediately, with no pending write completing.

Test Plan:
- Reset release, io_read=1 addr=0x078 -> rdata=0 in the first cycle, then 1, 2, 3 on successive edges; led_out=0, seg_data=0, addr_err=0.
- io_write=1 addr=0x070 wdata=0xABCD1234 for one cycle -> led_out=0x1234 next cycle. Read 0x070 -> rdata=0x00001234. Write 0x074 with 0xDEADBEEF -> seg_data=0xDEADBEEF.
- sw_in=0x5A5A -> read 0x060 returns 0 for 2 edges, then 0x00005A5A.
- btn_in[2] high held 25 cycles with DEBOUNCE_CYCLES=20:
  - Read 0x064 -> 0x00040004 from edge 22 onward.
  - A clearing read then gives 0x00040000.
  - A 10-cycle pulse on btn_in[0] -> press stays 0.
- Write CYC=0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on consecutive cycles.
- io_read at 0x062 -> rdata=0, addr_err=1. io_write at 0x100 -> no register changes, addr_err stays 1. Assert rst_n=0 mid-write -> addr_err=0, led_out=0 immediately.
